// File: rtl/bomb_countdown_display.sv
// Countdown timer for the bomb-defusal game: BCD seconds count with strike penalties,
// defuse/explode outcomes, and a multiplexed common-anode seven-segment scan.

module bomb_bcd_dec_digit (
  input  logic [3:0] d,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out
);
  always_comb begin
    borrow_out = borrow_in && (d == 4'd0);
    if (!borrow_in)     q = d;
    else if (d == 4'd0) q = 4'd9;
    else                q = d - 4'd1;
  end
endmodule

module bomb_countdown_display #(
  parameter int CLK_HZ          = 100000000,
  parameter int NUM_DIGITS      = 4,
  parameter int START_SECONDS   = 45,
  parameter int ALARM_THRESHOLD = 7,
  parameter int PENALTY_SECONDS = 5,
  parameter int DIGIT_TICKS     = 262144
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  defuse,
  input  logic                  strike,
  output logic                  running,
  output logic                  defused,
  output logic                  alarm,
  output logic                  noTime,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);
  localparam int PW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCW = $clog2(PENALTY_SECONDS + 1);

  function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
    logic [4*NUM_DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  typedef enum logic [2:0] {IDLE, RUNNING, PENALTY, DEFUSED, EXPLODED} state_t;

  // {running, defused, noTime} for a given state
  function automatic logic [2:0] flags(input state_t s);
    case (s)
      RUNNING, PENALTY: return 3'b100;
      DEFUSED:          return 3'b010;
      EXPLODED:         return 3'b001;
      default:          return 3'b000;
    endcase
  endfunction

  localparam logic [4*NUM_DIGITS-1:0] START_BCD = to_bcd(START_SECONDS);
  localparam logic [4*NUM_DIGITS-1:0] ALARM_BCD = to_bcd(ALARM_THRESHOLD);
  localparam state_t START_STATE = (START_SECONDS == 0) ? EXPLODED : RUNNING;
  localparam logic [NUM_DIGITS-1:0] LEFT_EN = NUM_DIGITS'(1) << (NUM_DIGITS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   count;
  logic [NUM_DIGITS-1:0][3:0]   count_dec;
  logic [NUM_DIGITS-1:0][3:0]   count_next;
  logic [NUM_DIGITS:0]          borrow;
  logic [PW-1:0]                prescaler;
  logic [PCW-1:0]               pen_cnt;
  logic [RW-1:0]                refresh;
  logic [IW-1:0]                digit_idx;
  logic                         count_zero;
  logic                         hit_zero;
  logic                         alarm_zone;

  // Borrow ripples from the least-significant digit; a borrow out of the top means count==0.
  assign borrow[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    bomb_bcd_dec_digit u_dig (
      .d          (count[i]),
      .borrow_in  (borrow[i]),
      .q          (count_dec[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign count_zero = borrow[NUM_DIGITS];
  assign count_next = count_zero ? count : count_dec;
  assign hit_zero   = (count_next == '0);
  assign alarm_zone = !hit_zero && (count_next <= ALARM_BCD);

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state                      <= IDLE;
      {running, defused, noTime} <= 3'b000;
      count                      <= START_BCD;
      prescaler                  <= '0;
      pen_cnt                    <= '0;
      alarm                      <= 1'b0;
    end else if (start) begin
      state                      <= START_STATE;
      {running, defused, noTime} <= flags(START_STATE);
      count                      <= START_BCD;
      prescaler                  <= '0;
      pen_cnt                    <= '0;
      alarm                      <= 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          if (defuse) begin
            state                      <= DEFUSED;
            {running, defused, noTime} <= flags(DEFUSED);
            alarm                      <= 1'b0;
          end else if (strike) begin
            state                      <= PENALTY;
            {running, defused, noTime} <= flags(PENALTY);
            pen_cnt                    <= PCW'(PENALTY_SECONDS);
            alarm                      <= 1'b0;
          end else if (prescaler == PW'(CLK_HZ - 1)) begin
            prescaler <= '0;
            count     <= count_next;
            if (hit_zero) begin
              state                      <= EXPLODED;
              {running, defused, noTime} <= flags(EXPLODED);
              alarm                      <= 1'b0;
            end else begin
              alarm <= alarm_zone ? ~alarm : 1'b0;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        PENALTY: begin
          // prescaler is held so the second boundary resumes where it left off
          if (defuse) begin
            state                      <= DEFUSED;
            {running, defused, noTime} <= flags(DEFUSED);
          end else begin
            count   <= count_next;
            pen_cnt <= pen_cnt - 1'b1;
            if (hit_zero) begin
              state                      <= EXPLODED;
              {running, defused, noTime} <= flags(EXPLODED);
            end else if (pen_cnt == PCW'(1)) begin
              state                      <= RUNNING;
              {running, defused, noTime} <= flags(RUNNING);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Anode and cathodes are both registered from digit_idx, so they switch together.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      refresh        <= '0;
      digit_idx      <= '0;
      Anode_Activate <= '1;
      LED_out        <= 7'b1111111;
    end else begin
      if (refresh == RW'(DIGIT_TICKS - 1)) begin
        refresh   <= '0;
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh <= refresh + 1'b1;
      end
      Anode_Activate <= ~(LEFT_EN >> digit_idx);
      LED_out        <= seg7(count[LAST_IDX - digit_idx]);
    end
  end
endmodule

// File: tb/tb_bomb_countdown_display.sv
// Directed bench for bomb_countdown_display: scan/reset sequences by hand, then a
// table of {inputs, cycles, expected state outputs and count} records.

module tb_bomb_countdown_display;
  logic       clk = 1'b0;
  logic       reset, start, defuse, strike;
  logic       running, defused, alarm, noTime;
  logic [3:0] Anode_Activate;
  logic [6:0] LED_out;
  logic       running0, defused0, alarm0, noTime0;
  logic [3:0] an0;
  logic [6:0] led0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bomb_countdown_display #(
    .CLK_HZ(10), .NUM_DIGITS(4), .START_SECONDS(12),
    .ALARM_THRESHOLD(3), .PENALTY_SECONDS(5), .DIGIT_TICKS(4)
  ) dut (
    .clock_100Mhz(clk), .reset(reset), .start(start), .defuse(defuse), .strike(strike),
    .running(running), .defused(defused), .alarm(alarm), .noTime(noTime),
    .Anode_Activate(Anode_Activate), .LED_out(LED_out)
  );

  // zero reload: start must go straight to the exploded state
  bomb_countdown_display #(
    .CLK_HZ(10), .NUM_DIGITS(4), .START_SECONDS(0),
    .ALARM_THRESHOLD(3), .PENALTY_SECONDS(5), .DIGIT_TICKS(4)
  ) dut0 (
    .clock_100Mhz(clk), .reset(reset), .start(start), .defuse(defuse), .strike(strike),
    .running(running0), .defused(defused0), .alarm(alarm0), .noTime(noTime0),
    .Anode_Activate(an0), .LED_out(led0)
  );

  typedef struct {
    logic        rst, st, df, sk;
    int          n;
    logic        run, def, nt, al;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];
  logic [6:0] seg_tbl [10];

  function automatic void add(input logic rst, st, df, sk, input int n,
                              input logic run, def, nt, al, input logic [15:0] cnt);
    vec_t v;
    v = '{rst, st, df, sk, n, run, def, nt, al, cnt};
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    reset = v.rst; start = v.st; strike = v.sk; defuse = v.df;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; strike = 1'b0;
    repeat (v.n - 1) @(posedge clk);
    @(negedge clk);
    chk($sformatf("step%0d running", idx), running, v.run);
    chk($sformatf("step%0d defused", idx), defused, v.def);
    chk($sformatf("step%0d noTime", idx), noTime, v.nt);
    chk($sformatf("step%0d alarm", idx), alarm, v.al);
    chk($sformatf("step%0d count", idx), dut.count, v.cnt);
  endtask

  initial begin
    int         digs [4];
    int         d;
    logic [3:0] an_exp;

    seg_tbl[0] = 7'b0000001; seg_tbl[1] = 7'b1001111; seg_tbl[2] = 7'b0010010;
    seg_tbl[3] = 7'b0000110; seg_tbl[4] = 7'b1001100; seg_tbl[5] = 7'b0100100;
    seg_tbl[6] = 7'b0100000; seg_tbl[7] = 7'b0001111; seg_tbl[8] = 7'b0000000;
    seg_tbl[9] = 7'b0000100;
    digs = '{0, 0, 1, 2};

    //  rst st df sk   n  run def nt al  count
    add(1, 0, 0, 0,   2,  0, 0, 0, 0, 16'h0012);
    add(0, 1, 0, 0,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 0,   9,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 0,   1,  1, 0, 0, 0, 16'h0011);
    add(0, 0, 0, 0,  10,  1, 0, 0, 0, 16'h0010);
    add(0, 0, 0, 0,  10,  1, 0, 0, 0, 16'h0009);
    add(0, 0, 0, 0,  60,  1, 0, 0, 1, 16'h0003);
    add(0, 0, 0, 0,  10,  1, 0, 0, 0, 16'h0002);
    add(0, 0, 0, 0,  10,  1, 0, 0, 1, 16'h0001);
    add(0, 0, 0, 0,  10,  0, 0, 1, 0, 16'h0000);
    add(0, 0, 0, 1,   5,  0, 0, 1, 0, 16'h0000);
    add(0, 1, 0, 0,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 1,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 0,   4,  1, 0, 0, 0, 16'h0008);
    add(0, 0, 0, 0,   1,  1, 0, 0, 0, 16'h0007);
    add(0, 0, 0, 0,   9,  1, 0, 0, 0, 16'h0007);
    add(0, 0, 0, 0,   1,  1, 0, 0, 0, 16'h0006);
    add(0, 0, 0, 0,  30,  1, 0, 0, 1, 16'h0003);
    add(0, 0, 0, 1,   1,  1, 0, 0, 0, 16'h0003);
    add(0, 0, 0, 0,   2,  1, 0, 0, 0, 16'h0001);
    add(0, 0, 0, 0,   1,  0, 0, 1, 0, 16'h0000);
    add(0, 0, 0, 1,   3,  0, 0, 1, 0, 16'h0000);
    add(0, 1, 0, 0,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 0,  40,  1, 0, 0, 0, 16'h0008);
    add(0, 0, 1, 0,   1,  0, 1, 0, 0, 16'h0008);
    add(0, 0, 1, 1, 100,  0, 1, 0, 0, 16'h0008);
    add(0, 1, 0, 0,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 1,   3,  1, 0, 0, 0, 16'h0010);
    add(1, 1, 0, 1,   1,  0, 0, 0, 0, 16'h0012);
    add(0, 1, 0, 1,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 0,   1,  1, 0, 0, 0, 16'h0012);
    add(0, 0, 0, 1,   2,  1, 0, 0, 0, 16'h0011);
    add(0, 0, 1, 0,   1,  0, 1, 0, 0, 16'h0011);
    add(0, 0, 1, 0,   5,  0, 1, 0, 0, 16'h0011);

    // reset values, then a full scan of 0012 plus wrap
    reset = 1'b1; start = 1'b0; defuse = 1'b0; strike = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset anode", Anode_Activate, 4'b1111);
    chk("reset led", LED_out, 7'b1111111);
    chk("reset running", running, 1'b0);
    chk("reset alarm", alarm, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      d = ((k - 1) / 4) % 4;
      an_exp = ~(4'b1000 >> d);
      chk($sformatf("scan%0d anode", k), Anode_Activate, an_exp);
      chk($sformatf("scan%0d led", k), LED_out, seg_tbl[digs[d]]);
    end

    // reset mid-scan restarts from the leftmost digit
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midscan reset anode", Anode_Activate, 4'b1111);
    chk("midscan reset led", LED_out, 7'b1111111);
    @(posedge clk);
    @(negedge clk);
    chk("midscan restart anode", Anode_Activate, 4'b0111);
    chk("midscan restart led", LED_out, 7'b0000001);

    for (int i = 0; i < tv.size(); i++) step(tv[i], i);

    defuse = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("zero start noTime", noTime0, 1'b1);
    chk("zero start running", running0, 1'b0);
    chk("main start running", running, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
